// File: rtl/perf_counter_bank.sv
// Bank of per-channel event counters (level or edge counting, wrap or saturate)
// with sticky overflow flags, snapshot shadow registers and a registered read port.
module perf_counter_bank #(
    parameter int                NUM_CH    = 16,
    parameter int                CNT_WIDTH = 32,
    parameter logic [NUM_CH-1:0] EDGE_MASK = '0,
    parameter bit                SATURATE  = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [NUM_CH-1:0]    events,
    input  logic                 clear,
    input  logic                 clear_all,
    input  logic                 snapshot,
    input  logic                 rd_req,
    input  logic                 rd_snap,
    input  logic [4:0]           read_src,
    output logic [CNT_WIDTH-1:0] read_data,
    output logic                 rd_valid,
    output logic                 rd_ovf,
    output logic                 ovf_any
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] r_cnt    [NUM_CH];
    logic [CNT_WIDTH-1:0] r_shadow [NUM_CH];
    logic [NUM_CH-1:0]    r_ovf;
    logic [NUM_CH-1:0]    r_prev;
    logic [CNT_WIDTH-1:0] r_rd_data;
    logic                 r_rd_valid;
    logic                 r_rd_ovf;

    logic [NUM_CH-1:0]    w_inc;
    logic [NUM_CH-1:0]    w_clr;
    logic [CNT_WIDTH-1:0] w_rd_sel;
    logic                 w_ovf_sel;

    // Read handshake: rd_req is a single-cycle request with no backpressure; every
    // request sampled at an edge yields exactly one rd_valid pulse on the next cycle.
    // A read_src with no matching channel falls through to the zero defaults below.
    always_comb begin
        w_inc     = '0;
        w_clr     = '0;
        w_rd_sel  = '0;
        w_ovf_sel = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_inc[i] = enable && events[i] && !(EDGE_MASK[i] && r_prev[i]);
            w_clr[i] = clear_all || (clear && (read_src == 5'(i)));
            if (read_src == 5'(i)) begin
                w_rd_sel  = rd_snap ? r_shadow[i] : r_cnt[i];
                w_ovf_sel = r_ovf[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i]    <= '0;
                r_shadow[i] <= '0;
            end
            r_ovf      <= '0;
            r_prev     <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_rd_ovf   <= 1'b0;
        end else begin
            r_prev     <= events;
            r_rd_valid <= rd_req;
            if (rd_req) begin
                r_rd_data <= w_rd_sel;
                r_rd_ovf  <= w_ovf_sel;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                // Shadows take the value held before this edge's increments/clears.
                if (snapshot) begin
                    r_shadow[i] <= r_cnt[i];
                end
                if (w_clr[i]) begin
                    r_cnt[i] <= '0;
                    r_ovf[i] <= 1'b0;
                end else if (w_inc[i]) begin
                    if (r_cnt[i] == CNT_MAX) begin
                        r_ovf[i] <= 1'b1;
                        r_cnt[i] <= SATURATE ? CNT_MAX : '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + CNT_ONE;
                    end
                end
            end
        end
    end

    assign read_data = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign rd_ovf    = r_rd_ovf;
    assign ovf_any   = |r_ovf;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Bench for perf_counter_bank: a wrapping and a saturating 4-channel, 8-bit instance
// share stimulus; a counting model feeds expected reads to a negedge monitor.
module tb_perf_counter_bank;
    localparam int         NCH  = 4;
    localparam logic [3:0] EDGE = 4'b1010;

    logic       clk = 1'b0;
    logic       rst, enable, clear, clear_all, snapshot, rd_req, rd_snap;
    logic [3:0] events;
    logic [4:0] read_src;

    logic [7:0] w_data, s_data;
    logic       w_valid, s_valid, w_ovf, s_ovf, w_any, s_any;

    int n_cmp = 0;
    int n_err = 0;

    // model state: counts as plain integers, index [instance][channel]
    int         m_cnt    [2][NCH];
    int         m_shadow [2][NCH];
    bit         m_ovf    [2][NCH];
    bit         m_prev   [NCH];
    int         m_last_data [2];
    logic [8:0] exp_q0[$];
    logic [8:0] exp_q1[$];

    always #5 clk = ~clk;

    perf_counter_bank #(.NUM_CH(NCH), .CNT_WIDTH(8), .EDGE_MASK(EDGE), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .enable(enable), .events(events), .clear(clear),
        .clear_all(clear_all), .snapshot(snapshot), .rd_req(rd_req), .rd_snap(rd_snap),
        .read_src(read_src), .read_data(w_data), .rd_valid(w_valid), .rd_ovf(w_ovf),
        .ovf_any(w_any)
    );

    perf_counter_bank #(.NUM_CH(NCH), .CNT_WIDTH(8), .EDGE_MASK(EDGE), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .enable(enable), .events(events), .clear(clear),
        .clear_all(clear_all), .snapshot(snapshot), .rd_req(rd_req), .rd_snap(rd_snap),
        .read_src(read_src), .read_data(s_data), .rd_valid(s_valid), .rd_ovf(s_ovf),
        .ovf_any(s_any)
    );

    task automatic chk(input string name, input int s, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s inst%0d: got %0d, expected %0d at %0t", name, s, act, exp, $time);
        end
    endtask

    // ---------------- reference model, applied at each rising edge ----------------
    task automatic model_edge();
        logic [8:0] e;
        int         nxt;
        bit         counts;
        if (rst) begin
            for (int s = 0; s < 2; s++) begin
                for (int i = 0; i < NCH; i++) begin
                    m_cnt[s][i] = 0; m_shadow[s][i] = 0; m_ovf[s][i] = 0;
                end
                m_last_data[s] = 0;
            end
            for (int i = 0; i < NCH; i++) m_prev[i] = 0;
            exp_q0.delete();
            exp_q1.delete();
            return;
        end
        for (int s = 0; s < 2; s++) begin
            if (rd_req) begin
                e = '0;
                if (int'(read_src) < NCH) begin
                    e[8]   = m_ovf[s][read_src];
                    e[7:0] = 8'(rd_snap ? m_shadow[s][read_src] : m_cnt[s][read_src]);
                end
                if (s == 0) exp_q0.push_back(e);
                else        exp_q1.push_back(e);
                m_last_data[s] = int'(e[7:0]);
            end
            if (snapshot) begin
                for (int i = 0; i < NCH; i++) m_shadow[s][i] = m_cnt[s][i];
            end
            for (int i = 0; i < NCH; i++) begin
                counts = enable && (EDGE[i] ? (events[i] && !m_prev[i]) : events[i]);
                if (clear_all || (clear && int'(read_src) == i)) begin
                    m_cnt[s][i] = 0;
                    m_ovf[s][i] = 0;
                end else if (counts) begin
                    nxt = m_cnt[s][i] + 1;
                    if (nxt > 255) begin
                        m_ovf[s][i] = 1;
                        nxt = (s == 1) ? 255 : nxt % 256;
                    end
                    m_cnt[s][i] = nxt;
                end
            end
        end
        for (int i = 0; i < NCH; i++) m_prev[i] = events[i];
    endtask

    always @(posedge clk) model_edge();

    // ---------------- monitor: pops expectations whenever outputs settle ----------------
    task automatic check_inst(input int s, input logic v, input logic [7:0] d,
                              input logic o, input logic oa);
        logic [8:0] e;
        int         have;
        bit         any;
        have = (s == 0) ? exp_q0.size() : exp_q1.size();
        chk("rd_valid", s, 64'(v), 64'(have != 0));
        if (have != 0) begin
            if (s == 0) e = exp_q0.pop_front();
            else        e = exp_q1.pop_front();
            if (v) begin
                chk("read_data", s, 64'(d), 64'(e[7:0]));
                chk("rd_ovf", s, 64'(o), 64'(e[8]));
            end
        end else if (!v) begin
            chk("read_hold", s, 64'(d), 64'(m_last_data[s]));
        end
        any = 0;
        for (int i = 0; i < NCH; i++) any |= m_ovf[s][i];
        chk("ovf_any", s, 64'(oa), 64'(any));
    endtask

    always @(negedge clk) begin
        check_inst(0, w_valid, w_data, w_ovf, w_any);
        check_inst(1, s_valid, s_data, s_ovf, s_any);
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        enable = 1'b1; events = '0; clear = 1'b0; clear_all = 1'b0;
        snapshot = 1'b0; rd_req = 1'b0; rd_snap = 1'b0; read_src = '0;
    endtask

    task automatic events_for(input logic [3:0] ev, input int n);
        events = ev;
        repeat (n) tick();
        events = '0;
    endtask

    task automatic do_clear_all();
        clear_all = 1'b1;
        tick();
        clear_all = 1'b0;
    endtask

    task automatic read_ch(input int src, input bit snap);
        rd_req = 1'b1; rd_snap = snap; read_src = 5'(src);
        tick();
        rd_req = 1'b0; rd_snap = 1'b0;
    endtask

    // Explicit check of the read result presented just after the last edge.
    task automatic expect_rd(input string name, input int wd, input bit wo,
                             input int sd, input bit so);
        chk({name, "_valid"}, 0, 64'(w_valid), 64'd1);
        chk({name, "_data"},  0, 64'(w_data),  64'(wd));
        chk({name, "_ovf"},   0, 64'(w_ovf),   64'(wo));
        chk({name, "_valid"}, 1, 64'(s_valid), 64'd1);
        chk({name, "_data"},  1, 64'(s_data),  64'(sd));
        chk({name, "_ovf"},   1, 64'(s_ovf),   64'(so));
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (3) tick();
        chk("reset_data", 0, 64'(w_data), 64'd0);
        chk("reset_valid", 0, 64'(w_valid), 64'd0);
        chk("reset_ovf_any", 1, 64'(s_any), 64'd0);
        rst = 1'b0;

        // level counting
        events_for(4'b0001, 5);
        read_ch(0, 1'b0);
        expect_rd("level_ch0", 5, 0, 5, 0);

        // edge vs level with the same pattern
        do_clear_all();
        events_for(4'b0110, 5);
        events_for(4'b0000, 1);
        events_for(4'b0110, 2);
        read_ch(1, 1'b0);
        expect_rd("edge_ch1", 2, 0, 2, 0);
        read_ch(2, 1'b0);
        expect_rd("level_ch2", 7, 0, 7, 0);

        // enable low holds the counters
        do_clear_all();
        events_for(4'b0001, 3);
        enable = 1'b0;
        events_for(4'b0001, 4);
        enable = 1'b1;
        read_ch(0, 1'b0);
        expect_rd("enable_hold", 3, 0, 3, 0);

        // event + clear + snapshot + read on the same channel in one cycle
        do_clear_all();
        events_for(4'b0100, 10);
        events = 4'b0100; clear = 1'b1; read_src = 5'd2; snapshot = 1'b1;
        rd_req = 1'b1; rd_snap = 1'b0;
        tick();
        expect_rd("collide_read", 10, 0, 10, 0);
        idle_inputs();
        read_ch(2, 1'b0);
        expect_rd("collide_live", 0, 0, 0, 0);
        read_ch(2, 1'b1);
        expect_rd("collide_shadow", 10, 0, 10, 0);

        // overflow: wrap vs saturate
        do_clear_all();
        events_for(4'b0001, 256);
        read_ch(0, 1'b0);
        expect_rd("ovf_256", 0, 1, 255, 1);
        chk("ovf_any_256", 0, 64'(w_any), 64'd1);
        chk("ovf_any_256", 1, 64'(s_any), 64'd1);
        events_for(4'b0001, 44);
        read_ch(0, 1'b0);
        expect_rd("ovf_300", 44, 1, 255, 1);
        clear = 1'b1; read_src = 5'd0;
        tick();
        clear = 1'b0;
        chk("ovf_cleared", 0, 64'(w_any), 64'd0);
        chk("ovf_cleared", 1, 64'(s_any), 64'd0);
        read_ch(0, 1'b0);
        expect_rd("after_clear", 0, 0, 0, 0);

        // out-of-range channel: read returns zero, clear is ignored
        events_for(4'b1111, 3);
        read_ch(5, 1'b0);
        expect_rd("oor_read", 0, 0, 0, 0);
        clear = 1'b1; read_src = 5'd6;
        tick();
        clear = 1'b0;
        read_ch(0, 1'b0);
        expect_rd("oor_clear", 3, 0, 3, 0);

        // reset in the middle of counting with a read pending
        snapshot = 1'b1;
        tick();
        snapshot = 1'b0;
        events = 4'b1111; rd_req = 1'b1; read_src = 5'd0; rst = 1'b1;
        tick();
        chk("rst_drop_valid", 0, 64'(w_valid), 64'd0);
        chk("rst_drop_valid", 1, 64'(s_valid), 64'd0);
        chk("rst_data", 0, 64'(w_data), 64'd0);
        rst = 1'b0; events = '0; rd_req = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            read_ch(c, 1'b0);
            expect_rd("rst_live", 0, 0, 0, 0);
            read_ch(c, 1'b1);
            expect_rd("rst_shadow", 0, 0, 0, 0);
        end

        // randomized traffic, checked by the model through the monitor
        for (int c = 0; c < 3000; c++) begin
            enable    = ($urandom_range(0, 9) != 0);
            for (int i = 0; i < NCH; i++) events[i] = ($urandom_range(0, 7) != 0);
            clear     = ($urandom_range(0, 99) == 0);
            clear_all = ($urandom_range(0, 999) == 0);
            snapshot  = ($urandom_range(0, 9) == 0);
            rd_req    = 1'($urandom_range(0, 1));
            rd_snap   = 1'($urandom_range(0, 1));
            read_src  = 5'($urandom_range(0, 5));
            rst       = ($urandom_range(0, 1499) == 0);
            tick();
        end
        idle_inputs();
        rst = 1'b0;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
